spi_slave_fd: RTL
=================

Name: spi_slave_fd

Overview:
Parametrised full-duplex SPI slave, the successor to the fixed 8-bit receive-only slave. Oversamples SCK/SSEL/MOSI in the system clk domain and supports all four SPI modes and any word width. Receives back-to-back words within one SSEL frame, with a valid/ready transmit path driving MISO. Sits between the external SPI pins and the command decoder / register file.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first
IDLE_WORD, {WIDTH{1'b1}}, word transmitted when no tx data is held at a word start

Ports:
clk  in  1  system clock; must be at least 8x the SCK frequency
rst_n  in  1  asynchronous active-low reset
SCK  in  1  SPI clock (async)
SSEL  in  1  SPI select, active low (async)
MOSI  in  1  SPI data in (async)
MISO  out  1  SPI data out, registered
miso_oe  out  1  high while SSEL is active (synchronised); drives the pad tristate
rx_data  out  WIDTH  last complete received word
rx_valid  out  1  one-cycle pulse when rx_data updates
tx_data  in  WIDTH  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  holding register empty
tx_underrun  out  1  one-cycle pulse: a word started with no held tx data
frame_err  out  1  one-cycle pulse: SSEL deasserted mid-word

Behaviour:
- Sync: SCK and SSEL through 3-flop shift registers, MOSI through 2 flops. Edges are detected on stages [2:1]; SSEL active = ~SSELr[1]. All reset to idle (SCK = CPOL, SSEL = 1, MOSI = 0).
- Edges: leading = rising if CPOL=0, falling if CPOL=1. sample_edge = leading if CPHA=0, else trailing. shift_edge is the other edge.
- Reset values: MISO=IDLE_WORD first-out bit, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_err=0, bitcnt=0, hold empty, state IDLE. Reset asserted mid-frame aborts immediately; no pulses are produced.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on SSEL going active. On that same cycle: load the shift register from hold if full (clear hold), else from IDLE_WORD and pulse tx_underrun. Drive MISO with the first-out bit.
  - ACTIVE -> IDLE on SSEL inactive. If bitcnt != 0, pulse frame_err and discard the partial word (no rx_valid). bitcnt returns to 0.
- Shifting:
  - On each sample_edge in ACTIVE: shift MOSI_data into rx_shift (direction per MSB_FIRST) and increment bitcnt.
  - When bitcnt == WIDTH-1 at a sample_edge: rx_data <= completed word, rx_valid=1 on the next cycle (one-clk pulse), bitcnt wraps to 0.
  - On each shift_edge: advance the tx shift register and update MISO. Exception: with CPHA=1, the first leading edge of a word presents the first-out bit; no shift occurs.
  - Word boundary within a frame (bitcnt wrapped to 0): reload tx shift from hold or IDLE_WORD at that wrap, with the same underrun rule. The new first bit appears on MISO by the next shift_edge (CPHA=0) or the next leading edge (CPHA=1).
- rx has no backpressure. The consumer must take rx_data within WIDTH SCK periods; rx_data is stable until the next rx_valid.
- tx handshake:
  - Write hold on tx_valid && tx_ready.
  - tx_ready = ~hold_full, registered; it falls the cycle after acceptance.
  - If a load and a write occur in the same cycle, the load takes the old hold and the write fills hold; tx_ready stays 0.
  - Hold persists across frames.
- Counter width: $clog2(WIDTH), wraps modulo WIDTH exactly (not a power of 2 in general).
- SCK edges while SSEL is inactive are ignored.

Optional Feature:
SPI_SLAVE_FD_WORDCNT_EN:
- Defined: adds output word_cnt [15:0]. Cleared on SSEL activation and incremented on each rx_valid, saturating at 16'hFFFF. Holds its value after the frame ends until the next activation. Reset value 0.
- Undefined: the port and its logic are absent.

Test Plan:
- WIDTH=8, mode 0. Preload tx_data=8'hA5. Master sends 8'h3C -> rx_valid once with rx_data=8'h3C; master reads 8'hA5 on MISO; tx_ready returns 1.
- Mode 3 (CPOL=1, CPHA=1), WIDTH=16. Frame of 2 words, 16'h1234 and 16'hBEEF, with tx 16'h0F0F preloaded and 16'hF00D supplied mid-word-1 -> two rx_valid pulses with matching data; master receives 16'h0F0F then 16'hF00D.
- No tx data loaded, frame of 1 word -> tx_underrun pulses at SSEL activation; master receives IDLE_WORD (8'hFF).
- SSEL released after 5 of 8 bits -> frame_err pulse, no rx_valid, rx_data unchanged. The next full frame with 8'h81 receives 8'h81 correctly.
- MSB_FIRST=0, WIDTH=12. Master sends 12'h801 LSB-first -> rx_data=12'h801. rst_n asserted mid-frame -> all outputs at reset values asynchronously; no pulses follow.
- With SPI_SLAVE_FD_WORDCNT_EN: frame of 3 words -> word_cnt=3 after the frame; it clears to 0 at the next SSEL activation.

Source files
------------

// File: rtl/spi_slave_fd.sv
// spi_slave_fd: parametrised full-duplex SPI slave, oversampled in the clk domain.
// Supports all four SPI modes (CPOL/CPHA), any word width 2..32 and either bit
// order. Receives back-to-back words inside one SSEL frame. Transmit data comes
// in through a one-word holding register with a valid/ready handshake.
//
// Optional build macro: SPI_SLAVE_FD_WORDCNT_EN adds the word_cnt output.
//
// Ports:
//   clk, rst_n          system clock (>= 8x SCK), async active-low reset
//   SCK, SSEL, MOSI     asynchronous SPI pins (SSEL active low)
//   MISO, miso_oe       registered serial output and its pad enable
//   rx_data, rx_valid   last complete received word, one-cycle update pulse
//   tx_data, tx_valid   next word to transmit, accepted when tx_ready is high
//   tx_ready            holding register empty
//   tx_underrun         pulse: a word started with no held tx data
//   frame_err           pulse: SSEL released mid-word
//   word_cnt            (optional) words received in the current/last frame
module spi_slave_fd #(
    parameter int unsigned       WIDTH     = 8,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0]  IDLE_WORD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCK,
    input  logic             SSEL,
    input  logic             MOSI,
    output logic             MISO,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_err
`ifdef SPI_SLAVE_FD_WORDCNT_EN
    ,
    output logic [15:0]      word_cnt
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Bit that leaves the shift register first for the configured bit order
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Tx shift register after one bit has been sent
    function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic [2:0] sck_r;
    logic [2:0] ssel_r;
    logic [1:0] mosi_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_r  <= {3{CPOL}};
            ssel_r <= 3'b111;
            mosi_r <= 2'b00;
        end else begin
            sck_r  <= {sck_r[1:0], SCK};
            ssel_r <= {ssel_r[1:0], SSEL};
            mosi_r <= {mosi_r[0], MOSI};
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic ssel_act;
    logic ssel_fall;
    logic mosi_data;

    // Edge classification by mode
    always_comb begin
        sck_rise    = (sck_r[2:1] == 2'b01);
        sck_fall    = (sck_r[2:1] == 2'b10);
        lead_edge   = CPOL ? sck_fall : sck_rise;
        trail_edge  = CPOL ? sck_rise : sck_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        ssel_act    = ~ssel_r[1];
        ssel_fall   = ssel_r[2] & ~ssel_r[1];
        mosi_data   = mosi_r[1];
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_nx;
    logic   start_c;
    logic   stop_c;
    logic   sample_en_c;
    logic   shift_en_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ssel_fall) state_nx = ACTIVE;
            ACTIVE:  if (!ssel_act) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // SCK edges only count while the frame is open
    always_comb begin
        start_c     = 1'b0;
        stop_c      = 1'b0;
        sample_en_c = 1'b0;
        shift_en_c  = 1'b0;
        unique case (state)
            IDLE: start_c = ssel_fall;
            ACTIVE: begin
                if (!ssel_act) begin
                    stop_c = 1'b1;
                end else begin
                    sample_en_c = sample_edge;
                    shift_en_c  = shift_edge;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             first_pend;
    logic             wrap_c;
    logic             load_c;
    logic             write_c;
    logic [WIDTH-1:0] load_word;

    always_comb begin
        wrap_c    = sample_en_c && (bitcnt == LAST_BIT);
        load_c    = start_c | wrap_c;
        write_c   = tx_valid & tx_ready;
        load_word = hold_full ? hold_data : IDLE_WORD;
        rx_next   = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_data}
                              : {mosi_data, rx_shift[WIDTH-1:1]};
    end

    // Holding register: a same-cycle load consumes the old word, the write refills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load_c & ~hold_full;
            if (write_c) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end else if (load_c) begin
                hold_full <= 1'b0;
                tx_ready  <= 1'b1;
            end
        end
    end

    // Transmit shifter. first_pend marks a freshly loaded word whose first
    // bit must be presented (not shifted past) at the next shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= IDLE_WORD;
            MISO       <= first_bit(IDLE_WORD);
            first_pend <= 1'b0;
        end else if (start_c) begin
            tx_shift   <= load_word;
            MISO       <= first_bit(load_word);
            first_pend <= CPHA;
        end else if (wrap_c) begin
            tx_shift   <= load_word;
            first_pend <= 1'b1;
        end else if (shift_en_c) begin
            if (first_pend) begin
                MISO       <= first_bit(tx_shift);
                first_pend <= 1'b0;
            end else begin
                tx_shift <= tx_adv(tx_shift);
                MISO     <= first_bit(tx_adv(tx_shift));
            end
        end
    end

    // Receive shifter and bit counter (wraps modulo WIDTH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= stop_c && (bitcnt != '0);
            miso_oe   <= (state_nx == ACTIVE);
            if (start_c || stop_c) begin
                bitcnt <= '0;
            end else if (sample_en_c) begin
                rx_shift <= rx_next;
                if (bitcnt == LAST_BIT) begin
                    bitcnt   <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + CW'(1);
                end
            end
        end
    end

`ifdef SPI_SLAVE_FD_WORDCNT_EN
    // Words received since the last SSEL activation, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 16'h0000;
        end else if (start_c) begin
            word_cnt <= 16'h0000;
        end else if (rx_valid && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule
